// File: rtl/exec_pkg.sv
// ---------------------------------------------------------------------------
// exec_pkg
// Shared encodings for the execute stage: ALU function codes, MDU operation
// codes, forward-select codes and the iterative multiply/divide state enum.
// No ports; imported by exec_alu, mdu_iter and exec_stage_mdu.
// ---------------------------------------------------------------------------
package exec_pkg;

  // ALU function codes carried on ALUcontrolE
  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_XOR  = 4'd3;
  localparam logic [3:0] ALU_NOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_SLTU = 4'd10;

  // Multiply/divide unit operation carried on MduOpE
  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MFHI  = 3'd5,
    MDU_MFLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

  // Forward-select codes; 2'b11 behaves like FWD_SRC
  localparam logic [1:0] FWD_SRC  = 2'b00;
  localparam logic [1:0] FWD_RESW = 2'b01;
  localparam logic [1:0] FWD_ALUM = 2'b10;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_e;

  // Operations that launch an iterative multiply or divide
  function automatic logic isMduArith(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

  // Operations that need the MDU idle; the reserved code counts as NONE
  function automatic logic isMduActive(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd6);
  endfunction

endpackage

// File: rtl/exec_alu.sv
// ---------------------------------------------------------------------------
// exec_alu
// Combinational integer ALU. Shifts act on operand B by shamt_i.
// Ports: ctl_i (function code), a_i, b_i (operands), shamt_i (shift amount),
//        result_o (function result).
// ---------------------------------------------------------------------------
module exec_alu
  import exec_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CTL_W = 4
) (
  input  logic [CTL_W-1:0] ctl_i,
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  input  logic [4:0]       shamt_i,
  output logic [XLEN-1:0]  result_o
);

  logic ltSigned;
  logic ltUnsigned;

  assign ltSigned   = $signed(a_i) < $signed(b_i);
  assign ltUnsigned = a_i < b_i;

  always_comb begin
    result_o = '0;
    case (ctl_i)
      CTL_W'(ALU_AND):  result_o = a_i & b_i;
      CTL_W'(ALU_OR):   result_o = a_i | b_i;
      CTL_W'(ALU_ADD):  result_o = a_i + b_i;
      CTL_W'(ALU_XOR):  result_o = a_i ^ b_i;
      CTL_W'(ALU_NOR):  result_o = ~(a_i | b_i);
      CTL_W'(ALU_SLL):  result_o = b_i << shamt_i;
      CTL_W'(ALU_SUB):  result_o = a_i - b_i;
      CTL_W'(ALU_SLT):  result_o = {{(XLEN-1){1'b0}}, ltSigned};
      CTL_W'(ALU_SRL):  result_o = b_i >> shamt_i;
      CTL_W'(ALU_SRA):  result_o = $unsigned($signed(b_i) >>> shamt_i);
      CTL_W'(ALU_SLTU): result_o = {{(XLEN-1){1'b0}}, ltUnsigned};
      default:          result_o = '0;
    endcase
  end

endmodule

// File: rtl/mdu_iter.sv
// ---------------------------------------------------------------------------
// mdu_iter
// Iterative radix-2 multiply/divide unit with architectural HI/LO.
// Operates on magnitudes and fixes the signs in a final cycle.
// Ports: CLK, RSTn (sync active-low), start (launch op this cycle),
//        op (MDU op code), a/b (operands), busy (not IDLE),
//        hi/lo (architectural HI and LO registers).
// ---------------------------------------------------------------------------
module mdu_iter
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CNT_W = $clog2(XLEN);

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  workHi_q, workLo_q, opB_q, dividend_q;
  logic [XLEN-1:0]  hi_q, lo_q;
  logic             isDiv_q, negRes_q, negRem_q;

  logic             signedOp, negA, negB, startDiv;
  logic [XLEN-1:0]  absA, absB;
  logic [XLEN:0]    mulSum, divShift, divDiff;
  logic [2*XLEN-1:0] prodFixed;
  logic [XLEN-1:0]  quotFixed, remFixed;

  assign signedOp = (op == MDU_MULT) || (op == MDU_DIV);
  assign startDiv = (op == MDU_DIV) || (op == MDU_DIVU);
  assign negA     = signedOp & a[XLEN-1];
  assign negB     = signedOp & b[XLEN-1];
  assign absA     = negA ? -a : a;
  assign absB     = negB ? -b : b;

  // Multiply: workLo holds the multiplier and shifts out one bit per step
  // while the partial product grows into workHi from the top.
  assign mulSum   = {1'b0, workHi_q} + (workLo_q[0] ? {1'b0, opB_q} : '0);

  // Restoring divide: the partial remainder in workHi takes the next dividend
  // bit from workLo; a borrow in bit XLEN means the trial subtract failed.
  assign divShift = {workHi_q, workLo_q[XLEN-1]};
  assign divDiff  = divShift - {1'b0, opB_q};

  assign prodFixed = negRes_q ? -{workHi_q, workLo_q} : {workHi_q, workLo_q};
  assign quotFixed = negRes_q ? -workLo_q : workLo_q;
  assign remFixed  = negRem_q ? -workHi_q : workHi_q;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q    <= MDU_IDLE;
      cnt_q      <= '0;
      workHi_q   <= '0;
      workLo_q   <= '0;
      opB_q      <= '0;
      dividend_q <= '0;
      isDiv_q    <= 1'b0;
      negRes_q   <= 1'b0;
      negRem_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      case (state_q)
        MDU_IDLE: begin
          if (start) begin
            workHi_q   <= '0;
            workLo_q   <= absA;
            opB_q      <= absB;
            dividend_q <= a;
            isDiv_q    <= startDiv;
            negRes_q   <= negA ^ negB;
            negRem_q   <= negA;
            cnt_q      <= '0;
            state_q    <= MDU_RUN;
          end
        end
        MDU_RUN: begin
          if (isDiv_q) begin
            if (!divDiff[XLEN]) begin
              workHi_q <= divDiff[XLEN-1:0];
              workLo_q <= {workLo_q[XLEN-2:0], 1'b1};
            end else begin
              workHi_q <= divShift[XLEN-1:0];
              workLo_q <= {workLo_q[XLEN-2:0], 1'b0};
            end
          end else begin
            workHi_q <= mulSum[XLEN:1];
            workLo_q <= {mulSum[0], workLo_q[XLEN-1:1]};
          end
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1)) begin
            state_q <= MDU_FIX;
          end
        end
        MDU_FIX: begin
          // A zero divisor leaves the dividend in HI and all-ones in LO,
          // whatever the iteration produced.
          if (isDiv_q) begin
            if (opB_q == '0) begin
              lo_q <= '1;
              hi_q <= dividend_q;
            end else begin
              lo_q <= quotFixed;
              hi_q <= remFixed;
            end
          end else begin
            {hi_q, lo_q} <= prodFixed;
          end
          state_q <= MDU_IDLE;
        end
        default: state_q <= MDU_IDLE;
      endcase
    end
  end

  assign busy = (state_q != MDU_IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/exec_stage_mdu.sv
// ---------------------------------------------------------------------------
// exec_stage_mdu
// MIPS execute stage: forwarding muxes, ALU-source and RegDst selects, ALU,
// iterative multiply/divide unit with HI/LO, and the EX/MEM register.
// Ports: CLK, RSTn (sync active-low); ID/EX control and operands (*E);
//        forward selects and resultW; StallM holds EX/MEM; StallE asks the
//        hazard unit to hold IF/ID/EX; registered EX/MEM outputs (*M).
// ---------------------------------------------------------------------------
module exec_stage_mdu
  import exec_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CTL_W = 4
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             RegWriteE,
  input  logic             MemToRegE,
  input  logic             MemWriteE,
  input  logic [CTL_W-1:0] ALUcontrolE,
  input  logic             ALUsrcE,
  input  logic             RegDstE,
  input  logic [2:0]       MduOpE,
  input  logic [XLEN-1:0]  SrcAE,
  input  logic [XLEN-1:0]  SrcBE,
  input  logic [RA_W-1:0]  rtE,
  input  logic [RA_W-1:0]  rdE,
  input  logic [1:0]       forwardAE,
  input  logic [1:0]       forwardBE,
  input  logic [XLEN-1:0]  resultW,
  input  logic [XLEN-1:0]  SignImmE,
  input  logic [4:0]       shamtE,
  input  logic             StallM,
  output logic             StallE,
  output logic [XLEN-1:0]  ALUresultM,
  output logic [XLEN-1:0]  WriteDataM,
  output logic [RA_W-1:0]  WriteRegM,
  output logic             RegWriteM,
  output logic             MemToRegM,
  output logic             MemWriteM
);

  logic [XLEN-1:0] srcA, srcBf, srcB, aluOut, resultE, mduHi, mduLo;
  logic [RA_W-1:0] writeRegE;
  logic            mduBusy, mduStart;

  logic [XLEN-1:0] aluResult_q, writeData_q;
  logic [RA_W-1:0] writeReg_q;
  logic            regWrite_q, memToReg_q, memWrite_q;

  always_comb begin
    case (forwardAE)
      FWD_RESW: srcA = resultW;
      FWD_ALUM: srcA = aluResult_q;
      default:  srcA = SrcAE;
    endcase
    case (forwardBE)
      FWD_RESW: srcBf = resultW;
      FWD_ALUM: srcBf = aluResult_q;
      default:  srcBf = SrcBE;
    endcase
  end

  assign srcB      = ALUsrcE ? SignImmE : srcBf;
  assign writeRegE = RegDstE ? rdE : rtE;

  exec_alu #(.XLEN(XLEN), .CTL_W(CTL_W)) uAlu (
    .ctl_i    (ALUcontrolE),
    .a_i      (srcA),
    .b_i      (srcB),
    .shamt_i  (shamtE),
    .result_o (aluOut)
  );

  // A start is refused while EX is held by either stall, so a held
  // instruction never launches the unit twice.
  assign StallE   = mduBusy && isMduActive(MduOpE);
  assign mduStart = isMduArith(MduOpE) && !StallE && !StallM;

  mdu_iter #(.XLEN(XLEN)) uMdu (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .start (mduStart),
    .op    (MduOpE),
    .a     (srcA),
    .b     (srcB),
    .busy  (mduBusy),
    .hi    (mduHi),
    .lo    (mduLo)
  );

  assign resultE = (MduOpE == MDU_MFHI) ? mduHi :
                   (MduOpE == MDU_MFLO) ? mduLo : aluOut;

  // A memory stall freezes EX/MEM outright; otherwise an EX stall turns the
  // captured instruction into a bubble by dropping its control bits.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      aluResult_q <= '0;
      writeData_q <= '0;
      writeReg_q  <= '0;
      regWrite_q  <= 1'b0;
      memToReg_q  <= 1'b0;
      memWrite_q  <= 1'b0;
    end else if (!StallM) begin
      aluResult_q <= resultE;
      writeData_q <= srcBf;
      writeReg_q  <= writeRegE;
      regWrite_q  <= RegWriteE & ~StallE;
      memToReg_q  <= MemToRegE & ~StallE;
      memWrite_q  <= MemWriteE & ~StallE;
    end
  end

  assign ALUresultM = aluResult_q;
  assign WriteDataM = writeData_q;
  assign WriteRegM  = writeReg_q;
  assign RegWriteM  = regWrite_q;
  assign MemToRegM  = memToReg_q;
  assign MemWriteM  = memWrite_q;

endmodule

// File: tb/tb_exec_stage_mdu.sv
// ---------------------------------------------------------------------------
// tb_exec_stage_mdu
// Self-checking bench for exec_stage_mdu with XLEN = 32. A behavioural model
// tracks EX/MEM, HI/LO and the MDU busy window using plain arithmetic; a
// compare process checks the DUT against it every cycle, and the directed
// sequence adds hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_exec_stage_mdu;
  import exec_pkg::*;

  localparam int XLEN  = 32;
  localparam int RA_W  = 5;
  localparam int CTL_W = 4;

  logic             CLK = 1'b0;
  logic             RSTn;
  logic             RegWriteE, MemToRegE, MemWriteE;
  logic [CTL_W-1:0] ALUcontrolE;
  logic             ALUsrcE, RegDstE;
  logic [2:0]       MduOpE;
  logic [XLEN-1:0]  SrcAE, SrcBE, resultW, SignImmE;
  logic [RA_W-1:0]  rtE, rdE;
  logic [1:0]       forwardAE, forwardBE;
  logic [4:0]       shamtE;
  logic             StallM;
  logic             StallE;
  logic [XLEN-1:0]  ALUresultM, WriteDataM;
  logic [RA_W-1:0]  WriteRegM;
  logic             RegWriteM, MemToRegM, MemWriteM;

  exec_stage_mdu #(.XLEN(XLEN), .RA_W(RA_W), .CTL_W(CTL_W)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .RegWriteE(RegWriteE), .MemToRegE(MemToRegE), .MemWriteE(MemWriteE),
    .ALUcontrolE(ALUcontrolE), .ALUsrcE(ALUsrcE), .RegDstE(RegDstE),
    .MduOpE(MduOpE), .SrcAE(SrcAE), .SrcBE(SrcBE), .rtE(rtE), .rdE(rdE),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .resultW(resultW),
    .SignImmE(SignImmE), .shamtE(shamtE), .StallM(StallM), .StallE(StallE),
    .ALUresultM(ALUresultM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
    .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .MemWriteM(MemWriteM)
  );

  // Free-running 10 ns clock
  always #5 CLK = ~CLK;

  int testsRun  = 0;
  int failCount = 0;

  // Model state: expected EX/MEM contents, HI/LO, and cycles of busy left
  logic             mValid = 1'b0;
  logic             mDataValid = 1'b0;
  logic             mRegWrite, mMemToReg, mMemWrite;
  logic [RA_W-1:0]  mWriteReg;
  logic [XLEN-1:0]  mAlu, mWData;
  logic [XLEN-1:0]  mHi = '0, mLo = '0, pendHi = '0, pendLo = '0;
  int               mBusyLeft = 0;
  logic [XLEN-1:0]  mdA, mdBf, mdB, mdRes;
  logic             mdStall, mdStart;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [XLEN-1:0] aluModel(input logic [3:0] ctl, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b, input logic [4:0] sh);
    case (ctl)
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_ADD:  return a + b;
      ALU_XOR:  return a ^ b;
      ALU_NOR:  return ~(a | b);
      ALU_SLL:  return b << sh;
      ALU_SUB:  return a - b;
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SRL:  return b >> sh;
      ALU_SRA:  return $unsigned($signed(b) >>> sh);
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default:  return '0;
    endcase
  endfunction

  // Returns {HI, LO} for an arithmetic MDU op using native 64-bit math
  function automatic logic [63:0] mduModel(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              ia, ib;
    logic [31:0]     q, r;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    ia = a;
    ib = b;
    case (op)
      MDU_MULT:  return sa * sb;
      MDU_MULTU: return ua * ub;
      MDU_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = ia / ib;
        r = ia % ib;
        return {r, q};
      end
      MDU_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = a / b;
        r = a % b;
        return {r, q};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Behavioural model: at every rising edge, work out what EX/MEM and HI/LO
  // must become from the inputs that were presented during the cycle.
  always @(posedge CLK) begin
    if (!RSTn) begin
      mValid = 1'b1; mDataValid = 1'b1;
      mRegWrite = 1'b0; mMemToReg = 1'b0; mMemWrite = 1'b0;
      mWriteReg = '0; mAlu = '0; mWData = '0;
      mHi = '0; mLo = '0; mBusyLeft = 0;
    end else begin
      mdStall = (mBusyLeft > 0) && (MduOpE >= 3'd1) && (MduOpE <= 3'd6);
      mdA  = (forwardAE == 2'b01) ? resultW : (forwardAE == 2'b10) ? mAlu : SrcAE;
      mdBf = (forwardBE == 2'b01) ? resultW : (forwardBE == 2'b10) ? mAlu : SrcBE;
      mdB  = ALUsrcE ? SignImmE : mdBf;
      if (MduOpE == MDU_MFHI)      mdRes = mHi;
      else if (MduOpE == MDU_MFLO) mdRes = mLo;
      else                         mdRes = aluModel(ALUcontrolE, mdA, mdB, shamtE);
      mdStart = (MduOpE >= 3'd1) && (MduOpE <= 3'd4) && (mBusyLeft == 0) && !StallM;
      if (!StallM) begin
        mRegWrite  = RegWriteE & !mdStall;
        mMemToReg  = MemToRegE & !mdStall;
        mMemWrite  = MemWriteE & !mdStall;
        mDataValid = !mdStall;
        mAlu       = mdRes;
        mWData     = mdBf;
        mWriteReg  = RegDstE ? rdE : rtE;
      end
      if (mBusyLeft > 0) begin
        mBusyLeft--;
        if (mBusyLeft == 0) begin
          mHi = pendHi;
          mLo = pendLo;
        end
      end else if (mdStart) begin
        {pendHi, pendLo} = mduModel(MduOpE, mdA, mdB);
        mBusyLeft = XLEN + 1;
      end
    end
  end

  // Compare process: on every falling edge, the DUT must match the model.
  // Data fields of a bubble are don't-care and are skipped.
  always @(negedge CLK) begin
    if (mValid) begin
      checkOutput("StallE", StallE, (mBusyLeft > 0) && (MduOpE >= 3'd1) && (MduOpE <= 3'd6));
      checkOutput("RegWriteM", RegWriteM, mRegWrite);
      checkOutput("MemToRegM", MemToRegM, mMemToReg);
      checkOutput("MemWriteM", MemWriteM, mMemWrite);
      if (mDataValid) begin
        checkOutput("ALUresultM", ALUresultM, mAlu);
        checkOutput("WriteDataM", WriteDataM, mWData);
        checkOutput("WriteRegM", WriteRegM, mWriteReg);
      end
    end
  end

  task automatic stepClock();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] ctl, input logic [4:0] rd, input logic regWrite);
    MduOpE = op; SrcAE = a; SrcBE = b; ALUcontrolE = ctl; rdE = rd; RegWriteE = regWrite;
    forwardAE = 2'b00; forwardBE = 2'b00; ALUsrcE = 1'b0; RegDstE = 1'b1;
    MemWriteE = 1'b0; MemToRegE = 1'b0; StallM = 1'b0;
    SignImmE = '0; shamtE = '0; rtE = '0; resultW = '0;
  endtask

  task automatic waitNotStalled(output int n);
    n = 0;
    while (StallE !== 1'b0 && n < 100) begin
      stepClock();
      n++;
    end
  endtask

  // Start an MDU op, read LO right behind it (stalls), then HI
  task automatic runMdu(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo);
    int n;
    applyStimulus(op, a, b, ALU_ADD, 5'd0, 1'b0);
    stepClock();
    applyStimulus(MDU_MFLO, 0, 0, ALU_ADD, 5'd2, 1'b1);
    waitNotStalled(n);
    checkOutput({name, " stall cycles"}, n, 33);
    stepClock();
    checkOutput({name, " LO"}, ALUresultM, expLo);
    applyStimulus(MDU_MFHI, 0, 0, ALU_ADD, 5'd3, 1'b1);
    stepClock();
    checkOutput({name, " HI"}, ALUresultM, expHi);
    checkOutput({name, " model HI"}, mHi, expHi);
    checkOutput({name, " model LO"}, mLo, expLo);
  endtask

  // Watchdog so a hung DUT still ends the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", failCount);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    int n;
    applyStimulus(MDU_NONE, 0, 0, ALU_ADD, 5'd0, 1'b0);
    RSTn = 1'b0;
    stepClock();
    stepClock();
    checkOutput("reset ALUresultM", ALUresultM, 0);
    checkOutput("reset RegWriteM", RegWriteM, 0);
    RSTn = 1'b1;

    // Plain ALU ops and forwarding
    applyStimulus(MDU_NONE, 2, 3, ALU_ADD, 5'd5, 1'b1);
    stepClock();
    checkOutput("add 2+3", ALUresultM, 5);
    applyStimulus(MDU_NONE, 100, 7, ALU_ADD, 5'd9, 1'b1);
    forwardAE = 2'b10;
    stepClock();
    checkOutput("fwd ALUresultM", ALUresultM, 12);
    checkOutput("fwd WriteRegM", WriteRegM, 9);
    applyStimulus(MDU_NONE, 32'hFFFF_FFFE, 1, ALU_SLT, 5'd3, 1'b1);
    stepClock();
    checkOutput("slt -2<1", ALUresultM, 1);
    applyStimulus(MDU_NONE, 10, 0, ALU_SUB, 5'd4, 1'b1);
    forwardBE = 2'b01; resultW = 3;
    stepClock();
    checkOutput("sub fwd resultW", ALUresultM, 7);
    checkOutput("WriteDataM fwd", WriteDataM, 3);
    applyStimulus(MDU_NONE, 0, 0, ALU_SLL, 5'd0, 1'b1);
    ALUsrcE = 1'b1; SignImmE = 32'h3; shamtE = 5'd4; RegDstE = 1'b0; rtE = 5'd6;
    stepClock();
    checkOutput("sll imm", ALUresultM, 32'h30);
    checkOutput("RegDst rt", WriteRegM, 6);
    applyStimulus(MDU_NONE, 0, 0, ALU_SRA, 5'd1, 1'b1);
    ALUsrcE = 1'b1; SignImmE = 32'hFFFF_FF00; shamtE = 5'd4;
    stepClock();
    checkOutput("sra imm", ALUresultM, 32'hFFFF_FFF0);

    // Multiply/divide results and corner cases
    runMdu("MULT -3*7", MDU_MULT, 32'hFFFF_FFFD, 7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    runMdu("DIVU 100/7", MDU_DIVU, 100, 7, 2, 14);
    runMdu("DIV -7/2", MDU_DIV, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runMdu("DIV MIN/-1", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000);
    runMdu("DIVU 5/0", MDU_DIVU, 5, 0, 5, 32'hFFFF_FFFF);

    // Memory stall freezes EX/MEM
    applyStimulus(MDU_NONE, 10, 20, ALU_ADD, 5'd4, 1'b1);
    MemWriteE = 1'b1;
    stepClock();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(MDU_NONE, i * 3 + 1, 5, ALU_SUB, 5'(7 + i), 1'b0);
      StallM = 1'b1;
      stepClock();
      checkOutput("StallM ALUresultM", ALUresultM, 30);
      checkOutput("StallM WriteRegM", WriteRegM, 4);
      checkOutput("StallM MemWriteM", MemWriteM, 1);
    end

    // MULT keeps iterating through a memory stall; reserved op never stalls
    applyStimulus(MDU_MULT, 1000, 32'hFFFF_FFFE, ALU_ADD, 5'd0, 1'b0);
    stepClock();
    for (int i = 1; i <= 33; i++) begin
      applyStimulus((i % 2 == 1) ? MDU_RSVD : MDU_NONE, i, i, ALU_ADD, 5'd1, 1'b1);
      StallM = (i >= 5 && i < 10);
      stepClock();
    end
    applyStimulus(MDU_MFLO, 0, 0, ALU_ADD, 5'd2, 1'b1);
    checkOutput("MULT idle at 33", StallE, 0);
    stepClock();
    checkOutput("MULT under StallM LO", ALUresultM, 32'hFFFF_F830);
    applyStimulus(MDU_MFHI, 0, 0, ALU_ADD, 5'd3, 1'b1);
    stepClock();
    checkOutput("MULT under StallM HI", ALUresultM, 32'hFFFF_FFFF);

    // Reset during RUN with an MFHI waiting
    applyStimulus(MDU_MULT, 5, 6, ALU_ADD, 5'd0, 1'b0);
    stepClock();
    applyStimulus(MDU_MFHI, 0, 0, ALU_ADD, 5'd3, 1'b1);
    for (int i = 0; i < 4; i++) stepClock();
    RSTn = 1'b0;
    stepClock();
    checkOutput("reset abort StallE", StallE, 0);
    checkOutput("reset abort ALUresultM", ALUresultM, 0);
    checkOutput("reset abort WriteRegM", WriteRegM, 0);
    checkOutput("reset abort RegWriteM", RegWriteM, 0);
    RSTn = 1'b1;
    stepClock();
    checkOutput("HI after reset", ALUresultM, 0);
    checkOutput("MFHI RegWriteM", RegWriteM, 1);
    applyStimulus(MDU_MFLO, 0, 0, ALU_ADD, 5'd2, 1'b1);
    stepClock();
    checkOutput("LO after reset", ALUresultM, 0);

    // Second MULT issued while busy waits for IDLE, then starts
    applyStimulus(MDU_MULT, 6, 7, ALU_ADD, 5'd0, 1'b0);
    stepClock();
    applyStimulus(MDU_MULTU, 32'hFFFF_FFFF, 2, ALU_ADD, 5'd0, 1'b0);
    waitNotStalled(n);
    checkOutput("MULTU wait cycles", n, 33);
    stepClock();
    applyStimulus(MDU_MFHI, 0, 0, ALU_ADD, 5'd3, 1'b1);
    waitNotStalled(n);
    checkOutput("MFHI wait cycles", n, 33);
    stepClock();
    checkOutput("MULTU HI", ALUresultM, 1);
    applyStimulus(MDU_MFLO, 0, 0, ALU_ADD, 5'd2, 1'b1);
    stepClock();
    checkOutput("MULTU LO", ALUresultM, 32'hFFFF_FFFE);

    applyStimulus(MDU_NONE, 0, 0, ALU_ADD, 5'd0, 1'b0);
    stepClock();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
